// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enabled dual-port RAM.
package dpram_pkg;

  localparam int unsigned LANE_W = 8;

  // Same-address collision policy selectors.
  localparam int unsigned RD_OLD         = 0;
  localparam int unsigned RD_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/dpram_be_pipe_if.sv
// Write/read bus of the dual-port RAM; master drives requests, slave returns data.
interface dpram_be_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                    wen;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   d_in;
  logic                    ren;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [DATA_WIDTH-1:0]   d_out;
  logic                    rd_valid;
  logic                    busy;

  modport master (
    output wen, waddr, be, d_in, ren, raddr,
    input  d_out, rd_valid, busy
  );

  modport slave (
    input  wen, waddr, be, d_in, ren, raddr,
    output d_out, rd_valid, busy
  );

endinterface

// File: rtl/dpram_be_array.sv
// Storage array: per-lane masked write, registered read, no reset.
module dpram_be_array
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH/LANE_W-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]        rdata_q
);

  localparam int unsigned NB    = DATA_WIDTH / LANE_W;
  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Masked lane write and read-before-write registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/dpram_be_pipe.sv
// Byte-enabled simple dual-port RAM with zero-clear engine, collision policy
// and optional output register.
module dpram_be_pipe
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned OUT_REG        = 1,
  parameter int unsigned READ_MODE      = RD_OLD,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rst,
  dpram_be_pipe_if.slave bus
);

  localparam int unsigned NB    = DATA_WIDTH / LANE_W;
  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
  localparam state_e ST_INIT  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic   BUSY_INIT = (CLEAR_ON_RESET != 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic                  mem_we_c, mem_re_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [NB-1:0]         mem_be_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Stage A: array read in flight plus forwarding info for a write-first collision.
  logic                  va_q, va_d;
  logic [NB-1:0]         fbe_q, fbe_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  // Stage B: first output register.
  logic                  vb_q, vb_d;
  logic [DATA_WIDTH-1:0] db_q, db_d;

  dpram_be_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we      (mem_we_c),
    .waddr   (mem_waddr_c),
    .wbe     (mem_be_c),
    .wdata   (mem_wdata_c),
    .re      (mem_re_c),
    .raddr   (bus.raddr),
    .rdata_q (mem_rdata)
  );

  // Clear FSM next state and write-port mux (clear engine vs user).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_waddr_c = bus.waddr;
    mem_be_c    = bus.be;
    mem_wdata_c = bus.d_in;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q[ADDR_WIDTH-1:0];
        mem_be_c    = '1;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we_c = bus.wen;
        mem_re_c = bus.ren;
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Read pipeline: collision forwarding merge into stage B.
  always_comb begin
    va_d    = mem_re_c;
    fbe_d   = '0;
    fdata_d = bus.d_in;
    if ((READ_MODE == RD_WRITE_FIRST) && mem_re_c && mem_we_c &&
        (bus.waddr == bus.raddr)) begin
      fbe_d = bus.be;
    end
    vb_d = va_q;
    db_d = db_q;
    if (va_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        db_d[i*LANE_W +: LANE_W] = fbe_q[i] ? fdata_q[i*LANE_W +: LANE_W]
                                            : mem_rdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= BUSY_INIT;
      va_q    <= 1'b0;
      fbe_q   <= '0;
      fdata_q <= '0;
      vb_q    <= 1'b0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      va_q    <= va_d;
      fbe_q   <= fbe_d;
      fdata_q <= fdata_d;
      vb_q    <= vb_d;
      db_q    <= db_d;
    end
  end

  assign bus.busy = busy_q;

  if (OUT_REG != 0) begin : g_oreg
    logic                  vc_q, vc_d;
    logic [DATA_WIDTH-1:0] dc_q, dc_d;

    // Extra output stage; holds data when no read completes.
    always_comb begin
      vc_d = vb_q;
      dc_d = vb_q ? db_q : dc_q;
    end

    // Output register stage C.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vc_q <= 1'b0;
        dc_q <= '0;
      end else begin
        vc_q <= vc_d;
        dc_q <= dc_d;
      end
    end

    assign bus.d_out    = dc_q;
    assign bus.rd_valid = vc_q;
  end else begin : g_noreg
    assign bus.d_out    = db_q;
    assign bus.rd_valid = vb_q;
  end

endmodule
